// File: rtl/finger_pattern_encoder.sv
// finger_pattern_encoder: 2-bit code to thermometer finger pattern with valid/ready handshake and done pulse.
// Define FINGER_RAMP_EN for a one-finger-per-STEP_CYCLES ramp; otherwise fingers jump straight to the target.
module finger_pattern_encoder #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [3:0] fingers,
    output logic [2:0] finger_count,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n, tgt, tgt_n, code_tgt;
    logic [3:0] fingers_n;

    if (STEP_CYCLES < 1 || STEP_CYCLES > 255) begin : g_bad_step
        $error("STEP_CYCLES must be within 1..255");
    end

`ifdef FINGER_RAMP_EN
    localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);
    logic [7:0] timer, timer_n;
    logic       step;
    assign step = timer == LAST;
`endif

    // Code 00 is the full hand; the other codes are their own finger count.
    assign code_tgt = code_in == 2'b00 ? 3'd4 : {1'b0, code_in};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tgt_n   = tgt;
`ifdef FINGER_RAMP_EN
        timer_n = timer;
`endif
        case (state)
            IDLE: begin
                if (code_valid) begin
                    tgt_n   = code_tgt;
                    state_n = code_tgt == cnt ? DONE : MOVE;
`ifdef FINGER_RAMP_EN
                    timer_n = '0;
`endif
                end
            end
            MOVE: begin
`ifdef FINGER_RAMP_EN
                timer_n = step ? 8'd0 : timer + 8'd1;
                if (step) begin
                    cnt_n   = tgt > cnt ? cnt + 3'd1 : cnt - 3'd1;
                    state_n = cnt_n == tgt ? DONE : MOVE;
                end
`else
                cnt_n   = tgt;
                state_n = DONE;
`endif
            end
            default: state_n = IDLE;
        endcase
        fingers_n = cnt_n >= 3'd4 ? 4'b1111 :
                    cnt_n == 3'd3 ? 4'b1110 :
                    cnt_n == 3'd2 ? 4'b1100 :
                    cnt_n == 3'd1 ? 4'b1000 : 4'b0000;
    end

    // fingers is registered from the next count so it never glitches through a non-thermometer value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= '0;
            fingers <= '0;
`ifdef FINGER_RAMP_EN
            timer   <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tgt     <= tgt_n;
            fingers <= fingers_n;
`ifdef FINGER_RAMP_EN
            timer   <= timer_n;
`endif
        end
    end

    assign finger_count = cnt;
    assign code_ready   = state == IDLE;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
endmodule

// File: tb/tb_finger_pattern_encoder.sv
// tb_finger_pattern_encoder: table of codes with expected patterns, scoreboard of pending results, plus reset sequences.
module tb_finger_pattern_encoder;
    localparam int STEP = 4;
`ifdef FINGER_RAMP_EN
    localparam int MID = 2;
`else
    localparam int MID = 4;
`endif

    typedef struct {
        logic [1:0] code;
        logic [3:0] pat;
        int         cnt;
        bit         hold;
    } vec_t;

    typedef struct {
        int         cnt0;
        int         tgt;
        logic [3:0] pat;
        int         lat;
    } exp_t;

    logic       clk, rst_n, code_valid, code_ready, busy, done;
    logic [1:0] code_in;
    logic [3:0] fingers;
    logic [2:0] finger_count;

    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;
    exp_t sb[$];
    vec_t vecs[8];

    finger_pattern_encoder #(.STEP_CYCLES(STEP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .code_in(code_in),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .fingers(fingers),
        .finger_count(finger_count),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic int therm(input int m);
        logic [7:0] t;
        t = 8'hF0 >> m;
        return int'(t[3:0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string name);
        chk({name, "_fingers"}, int'(fingers), 0);
        chk({name, "_count"}, int'(finger_count), 0);
        chk({name, "_ready"}, int'(code_ready), 1);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    task automatic send(input vec_t v);
        exp_t e, got;
        int   n, m;
        @(negedge clk);
        chk("ready_idle", int'(code_ready), 1);
        e.cnt0 = mcnt;
        e.tgt  = v.cnt;
        e.pat  = v.pat;
        n = v.cnt > mcnt ? v.cnt - mcnt : mcnt - v.cnt;
`ifdef FINGER_RAMP_EN
        e.lat = n * STEP;
`else
        e.lat = n == 0 ? 0 : 1;
`endif
        sb.push_back(e);
        code_in    = v.code;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_in    = v.hold ? 2'b01 : ~v.code;
        code_valid = v.hold;
        for (int j = 0; j <= e.lat; j++) begin
            @(negedge clk);
`ifdef FINGER_RAMP_EN
            m = j / STEP < n ? j / STEP : n;
`else
            m = j >= 1 ? n : 0;
`endif
            m = v.cnt >= e.cnt0 ? e.cnt0 + m : e.cnt0 - m;
            chk("count", int'(finger_count), m);
            chk("fingers", int'(fingers), therm(m));
            chk("busy", int'(busy), 1);
            chk("ready_busy", int'(code_ready), 0);
            chk("done", int'(done), int'(j == e.lat));
            if (j == e.lat) begin
                got = sb.pop_front();
                chk("final_pat", int'(fingers), int'(got.pat));
                chk("final_cnt", int'(finger_count), got.tgt);
            end
        end
        // valid may still be high through the done cycle; it must not be taken there
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        @(negedge clk);
        chk("ready_after", int'(code_ready), 1);
        chk("busy_after", int'(busy), 0);
        chk("done_after", int'(done), 0);
        chk("pat_after", int'(fingers), int'(v.pat));
        mcnt = v.cnt;
    endtask

    initial begin
        bit seen;
        vecs[0] = '{2'b00, 4'b1111, 4, 1'b0};
        vecs[1] = '{2'b01, 4'b1000, 1, 1'b0};
        vecs[2] = '{2'b10, 4'b1100, 2, 1'b0};
        vecs[3] = '{2'b10, 4'b1100, 2, 1'b0};
        vecs[4] = '{2'b11, 4'b1110, 3, 1'b0};
        vecs[5] = '{2'b01, 4'b1000, 1, 1'b0};
        vecs[6] = '{2'b00, 4'b1111, 4, 1'b1};
        vecs[7] = '{2'b11, 4'b1110, 3, 1'b0};

        rst_n      = 1'b0;
        code_valid = 1'b0;
        code_in    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_chk("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_chk("idle");
        end

        for (int i = 0; i < 8; i++) send(vecs[i]);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mcnt  = 0;
        code_in    = 2'b00;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = int'(finger_count) == MID;
        end
        chk("mid_seen", int'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        idle_chk("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        mcnt  = 0;
        send('{2'b11, 4'b1110, 3, 1'b0});

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/finger_pattern_encoder.md
# finger_pattern_encoder

- Converts a 2-bit finger code into the 4-bit finger thermometer pattern (A,B,C,D). It is the inverse of the finger decoder.
- It drives the finger outputs one finger at a time under a step timer, so every intermediate pattern is a legal thermometer value.
- Sits between the control logic producing 2-bit codes and the finger actuator/LED outputs.
- Accepts one code per valid/ready handshake and reports completion with a one-cycle done pulse.

## Interface
- STEP_CYCLES, 4, clock cycles between consecutive finger steps; legal range 1..255.
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- code_in  input  2  target code. 01 means 1000, 10 means 1100, 11 means 1110, 00 means 1111.
- code_valid  input  1  code_in is valid this cycle.
- code_ready  output  1  block can accept a code; high only in IDLE.
- fingers  output  4  pattern; bit3=A, bit2=B, bit1=C, bit0=D.
- finger_count  output  3  number of raised fingers, 0..4.
- busy  output  1  high in MOVE and DONE.
- done  output  1  one-cycle pulse when fingers reaches the target.

## Operation
- Internal finger count cnt (3 bits) and target tgt (3 bits).
- Code-to-target map: 01 gives 1, 10 gives 2, 11 gives 3, 00 gives 4.
- fingers is always the thermometer of cnt: 0→0000, 1→1000, 2→1100, 3→1110, 4→1111. It is registered and never shows a non-thermometer value.
- IDLE: code_ready=1.
  - An accept happens on a rising edge with code_valid=1. On accept, tgt is captured from code_in and the step timer is cleared.
  - If tgt==cnt, go to DONE; otherwise go to MOVE.
- MOVE: the timer counts 0..STEP_CYCLES-1. When the timer reaches STEP_CYCLES-1:
  - cnt moves by exactly 1 toward tgt (increment if tgt>cnt, decrement if tgt<cnt);
  - the timer wraps to 0;
  - if the new cnt equals tgt, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- code_valid outside IDLE is ignored; no queuing. code_in may change freely after the accept edge.
- cnt saturates in 0..4 by construction; tgt is never 0, so full release (0000) occurs only via reset.

## Timing
- Reset (async assert, sync-to-clk deassert by the system):
  - state=IDLE, cnt=0, tgt=0, timer=0;
  - fingers=0000, finger_count=0, code_ready=1, busy=0, done=0.
- Accept at edge T with a distance of n=|tgt-cnt| steps:
  - step k updates fingers at edge T+k·STEP_CYCLES;
  - done is high during the cycle after edge T+n·STEP_CYCLES;
  - code_ready returns high one cycle after done.
- n=0: done is high in the cycle after edge T, with no fingers change.
- Maximum latency (0→4) is 4·STEP_CYCLES cycles to the done edge.
- Reset mid-MOVE: outputs return to reset values immediately (asynchronously); the pending code is discarded.
- Back-to-back: a code presented while done=1 is not accepted; the earliest accept is the first IDLE edge.

## Configuration
- FINGER_RAMP_EN defined: stepwise ramp as specified above.
- FINGER_RAMP_EN undefined:
  - the step timer is removed and STEP_CYCLES is ignored;
  - in MOVE, cnt loads tgt directly on the first edge after accept, so fingers jumps straight to the target pattern;
  - done is high in the cycle after edge T+1 (n=0 still gives done after edge T).
- Handshake, reset values and the code map are identical in both builds.

## Test plan
- Reset then idle: with rst_n low, fingers=0000, code_ready=1, busy=0. Release reset and hold code_valid=0 for 20 cycles; outputs stay unchanged.
- Ramp up (STEP_CYCLES=4, FINGER_RAMP_EN): accept 00 at edge T from reset. fingers becomes 1000, 1100, 1110, 1111 at T+4, T+8, T+12, T+16. done is high in one cycle only, after T+16.
- Ramp down: from 1111, accept 01. fingers becomes 1110, 1100, 1000 at T+4, T+8, T+12. finger_count tracks 3, 2, 1. done follows T+12.
- Same target: at 1100, accept 10. fingers is unchanged, done is high in the cycle after T, and code_ready is high again one cycle later.
- Busy/async reset: during a 0→4 ramp, hold code_valid=1 with code 01; there is no accept and the ramp continues. Assert rst_n low mid-cycle at count 2; fingers=0000 with no clock edge.
- FINGER_RAMP_EN undefined: accept 11 from reset. fingers=1110 at T+1 and done follows T+1.
